// File: rtl/inst_mem_resp.sv
// Boot-loadable instruction memory: byte-stream loader (IDLE/LOAD/RUN) plus zero-latency fetch port.
// Define INST_MEM_WAIT_EN to register the fetch path (one stall cycle per new word address).
module inst_mem_resp #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  input  logic        load_start_i,
  input  logic [15:0] load_words_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_data_i,
  output logic        load_ready_o,
  output logic        load_done_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       words_q, words_d;
  logic [23:0]       shift_q, shift_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              stall_q, stall_d;

  logic              wr_en;
  logic [31:0]       wr_word;
  logic              byte_fire;
  logic              fetch_ok;
  logic [ADDR_W-1:0] rd_addr;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    words_d    = words_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    wr_word    = {shift_q, load_data_i};
    byte_fire  = load_valid_i && ready_q;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (load_start_i) begin
          words_d    = load_words_i;
          wr_ptr_d   = '0;
          byte_idx_d = '0;
          word_cnt_d = '0;
          if (load_words_i == 16'd0) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (byte_fire) begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], load_data_i};
          // Fourth byte completes a big-endian word; the pointer wraps naturally at ADDR_W bits.
          if (byte_idx_q == 2'd3) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == words_q) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LOAD);
    stall_d = (state_d != S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      words_q    <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      stall_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      words_q    <= words_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      stall_q    <= stall_d;
    end
  end

  // NOTE: the memory array has no reset; its contents deliberately survive reset and reloads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign fetch_ok = ce_i && (addr_i[1:0] == 2'b00) && (addr_i[31:ADDR_W+2] == '0) &&
                    (state_q == S_RUN);
  assign rd_addr  = addr_i[ADDR_W+1:2];

  assign load_ready_o = ready_q;
  assign load_done_o  = done_q;

`ifdef INST_MEM_WAIT_EN
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_hit;

  assign rd_hit = rd_valid_q && (rd_addr_q == rd_addr);

  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    // Entering RUN invalidates the held word so the first fetch always waits.
    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      rd_valid_d = 1'b0;
    end else if (fetch_ok && !rd_hit) begin
      rd_addr_d  = rd_addr;
      rd_data_d  = mem[rd_addr];
      rd_valid_d = 1'b1;
    end
    inst_o     = (fetch_ok && rd_hit) ? rd_data_q : NOP_WORD;
    stallreq_o = stall_q || (fetch_ok && !rd_hit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
`else
  always_comb begin
    inst_o     = fetch_ok ? mem[rd_addr] : NOP_WORD;
    stallreq_o = stall_q;
  end
`endif

endmodule
